// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// One pipeline stage register with a skid entry. The downstream interface
// is fully registered, so the stage can run at one entry per cycle without
// a combinational ready path between neighbouring stages.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high in that cycle. Upstream: accept = InValid & InReady.
// Downstream: issue = OutValid & OutReady. A valid entry, once presented,
// keeps its payload stable until it is issued. Ready never depends
// combinationally on valid on the same side.
//
// Entries:
//   MAIN - drives OutValid/OutData/OutCtrl.
//   SKID - catches the entry accepted in the cycle MAIN stalls.
//
// Ports:
//   Clk       clock, rising edge
//   Rst       synchronous active-high reset (highest priority)
//   Flush     synchronous kill of all held entries
//   InValid   upstream entry present
//   InReady   stage can accept this cycle (= !Rst & !SKID.valid)
//   InData    upstream data payload   [DATA_W]
//   InCtrl    upstream control payload [CTRL_W]
//   OutValid  MAIN holds a live entry
//   OutReady  downstream accepts (low = stall)
//   OutData   registered data payload [DATA_W]
//   OutCtrl   registered control payload [CTRL_W]
//   Count     occupancy 0..2; this is also the FSM state encoding
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
   parameter int DATA_W     = 32,
   parameter int CTRL_W     = 32,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Flush,
   input  logic              InValid,
   output logic              InReady,
   input  logic [DATA_W-1:0] InData,
   input  logic [CTRL_W-1:0] InCtrl,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [DATA_W-1:0] OutData,
   output logic [CTRL_W-1:0] OutCtrl,
   output logic [1:0]        Count
);

   // State values equal the occupancy so Count can expose the state directly.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stateT;

   stateT state;
   stateT nextState;

   logic              mainValid;
   logic [DATA_W-1:0] mainData;
   logic [CTRL_W-1:0] mainCtrl;
   logic              skidValid;
   logic [DATA_W-1:0] skidData;
   logic [CTRL_W-1:0] skidCtrl;

   logic accept;
   logic issue;

   // Datapath load controls decoded from the state.
   logic loadMainIn;
   logic loadMainSkid;
   logic loadSkidIn;
   logic dropMain;
   logic dropSkid;

   // InReady only looks at the SKID register (and Rst), never at OutReady.
   assign InReady = !Rst && !skidValid;
   assign accept  = InValid && InReady;
   assign issue   = mainValid && OutReady;

   assign OutValid = mainValid;
   assign OutData  = mainData;
   assign OutCtrl  = mainCtrl;
   assign Count    = state;

   // ---------------------------------------------------------------- state
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= EMPTY;
      end else begin
         state <= nextState;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      nextState = state;
      if (Flush) begin
         nextState = EMPTY;
      end else begin
         case (state)
            EMPTY: if (accept) nextState = ONE;
            ONE: begin
               if (accept && !issue) begin
                  nextState = FULL;
               end else if (issue && !accept) begin
                  nextState = EMPTY;
               end
            end
            FULL: if (issue) nextState = ONE;
            default: nextState = EMPTY;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   // Load/drop strobes for the entry registers. A flush overrides them all.
   always_comb begin
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkidIn   = 1'b0;
      dropMain     = 1'b0;
      dropSkid     = 1'b0;
      if (!Flush) begin
         case (state)
            EMPTY: loadMainIn = accept;
            ONE: begin
               loadMainIn = accept && issue;
               loadSkidIn = accept && !issue;
               dropMain   = issue && !accept;
            end
            FULL: begin
               // accept cannot happen here: InReady is low while SKID is valid
               loadMainSkid = issue;
               dropSkid     = issue;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------- datapath
   // Whenever a valid bit drops, its ctrl field is zeroed as well so a bubble
   // can never assert a control signal further down the pipe.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         mainValid <= 1'b0;
         mainData  <= '0;
         mainCtrl  <= '0;
         skidValid <= 1'b0;
         skidData  <= '0;
         skidCtrl  <= '0;
      end else if (Flush) begin
         mainValid <= 1'b0;
         mainCtrl  <= '0;
         skidValid <= 1'b0;
         skidCtrl  <= '0;
         if (CLEAR_DATA) begin
            mainData <= '0;
            skidData <= '0;
         end
      end else begin
         if (loadMainIn) begin
            mainValid <= 1'b1;
            mainData  <= InData;
            mainCtrl  <= InCtrl;
         end else if (loadMainSkid) begin
            mainValid <= skidValid;
            mainData  <= skidData;
            mainCtrl  <= skidCtrl;
         end else if (dropMain) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
         end

         if (loadSkidIn) begin
            skidValid <= 1'b1;
            skidData  <= InData;
            skidCtrl  <= InCtrl;
         end else if (dropSkid) begin
            skidValid <= 1'b0;
            skidCtrl  <= '0;
         end
      end
   end

endmodule
